core_divider: RTL and testbench
===============================

# core_divider

Iterative RV32M divide unit for the execute stage. It accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and runs a 32-step restoring shift-subtract loop under a small FSM. Divide-by-zero and signed overflow are handled in a single step. The result is held on a valid/ready response port until the pipeline consumes it. The single-cycle ALU stays combinational; this block is the multi-cycle sibling that the execute stage stalls on.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort any in-flight or completed operation (pipeline kill).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- src_a  in  32  dividend.
- src_b  in  32  divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- FSM states: IDLE, BUSY, DONE.
  - Reset state: IDLE.
  - req_ready = (state == IDLE).
  - resp_valid = (state == DONE).
- IDLE to BUSY: on req_valid && req_ready when the operation is normal. Latch the operation, the magnitudes |a| and |b|, and the signs; clear the 33-bit partial remainder; set the 5-bit step counter to 0.
  - Magnitudes are taken only for DIV/REM; DIVU/REMU use the raw operands.
- IDLE to DONE: on an accepted request that is a special case. resp_result is loaded directly from these rules:
  - src_b == 0, any op: quotient = 0xFFFFFFFF; remainder = src_a.
  - Signed op with src_a == 0x80000000 and src_b == 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- BUSY, each cycle:
  - Shift the dividend MSB into the partial remainder.
  - trial = rem − divisor (33-bit).
  - If trial is non-negative, rem = trial and the quotient bit is 1; otherwise keep rem and the quotient bit is 0.
  - The quotient shifts into the dividend register.
  - When counter == 31: go to DONE and load resp_result, applying the final sign fix in the same cycle.
    - Quotient is negated if op is DIV and sign_a ^ sign_b.
    - Remainder is negated if op is REM and sign_a.
  - Otherwise increment the counter.
- DONE to IDLE: on resp_ready. resp_result holds stable and unchanged for as long as resp_valid=1 && resp_ready=0.
- flush: from any state, next state is IDLE. Any pending result is discarded.
  - A request presented in the same cycle as flush is not accepted.
  - flush has priority over every other transition.
- rst: same effect as flush, plus it clears all registers.
  - Reset values: resp_valid=0, resp_result=0, req_ready=1 (IDLE).
  - A reset mid-operation discards the operation.
- Width rules:
  - Partial remainder is 33 bits so the trial subtraction sign is bit 32.
  - Negation is two's complement modulo 2^32.
  - The magnitude of 0x80000000 is 0x80000000, taken as unsigned.

## Timing
- Accept cycle is T (req_valid && req_ready sampled high).
- Normal op: BUSY covers T+1..T+32; resp_valid is first high at T+33.
  - With resp_ready=1 at T+33, the result is consumed and req_ready=1 at T+34.
- Special case: resp_valid is high at T+1.
- No back-to-back acceptance: at most one operation is outstanding.
- resp_ready is ignored outside DONE.
- req_valid is ignored outside IDLE; operands are not required to stay stable after T.
- Results depend only on values latched at T.

## Test plan
- DIV 20 / −3 (0x00000014, 0xFFFFFFFD) -> resp_result 0xFFFFFFFA, resp_valid exactly 33 cycles after accept. REM on the same operands -> 0x00000002. REM −20 / 3 -> 0xFFFFFFFE.
- DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF. REMU on the same operands -> 0x00000001. DIVU 0x80000000 / 0x80000000 -> 1.
- Divide by zero, all four ops, src_a=0x12345678, src_b=0:
  - DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> 0x12345678.
  - resp_valid at T+1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU on the same operands -> 0x00000000 after 33 cycles (normal path).
- Backpressure: hold resp_ready=0 for 10 cycles in DONE while toggling src_a and src_b -> resp_result stable, req_ready=0. Then resp_ready=1 -> IDLE on the next cycle.
- flush at T+15, and separately rst at T+15 -> IDLE on the next cycle, resp_valid never asserts, req_ready=1. A fresh DIV 100 / 7 afterwards -> 14.

Source files
------------

// File: rtl/core_divider.sv
// -----------------------------------------------------------------------------
// core_divider
//
// Iterative RV32M divide unit for the execute stage. It takes DIV, DIVU, REM
// and REMU requests over a valid/ready handshake. A normal operation runs a
// 32-step restoring shift-subtract loop. Divide-by-zero and signed overflow
// finish in one step. The result stays on a valid/ready response port until
// the pipeline takes it.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset; clears every register
//   flush        pipeline kill; drops any in-flight or completed operation
//   req_valid    a request is present
//   req_ready    the unit can accept a request (high only in IDLE)
//   req_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   src_a        dividend
//   src_b        divisor
//   resp_valid   a result is available (high only in DONE)
//   resp_ready   the consumer takes the result
//   resp_result  quotient (DIV/DIVU) or remainder (REM/REMU)
// -----------------------------------------------------------------------------
module core_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_REM  = 2'b10;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q;
  logic [1:0]  op_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [31:0] dividend_q;   // shifts left; quotient bits fill in from the LSB
  logic [31:0] divisor_q;
  logic [32:0] rem_q;        // partial remainder; bit 32 is spare headroom
  logic [4:0]  count_q;
  logic [31:0] result_q;

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_result = result_q;

  // ---------------------------------------------------------------------------
  // Request decode: operand magnitudes and the single-step special cases
  // ---------------------------------------------------------------------------
  logic        req_signed;
  logic        req_is_rem;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_by_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;
  logic        accept;

  always_comb begin
    // NOTE: every variable gets a value on every path through always_comb,
    // so synthesis builds plain logic and no latch.
    req_signed     = ~req_op[0];
    req_is_rem     = req_op[1];
    a_neg          = req_signed & src_a[31];
    b_neg          = req_signed & src_b[31];
    // The magnitude of INT_MIN wraps back to 0x80000000. That is correct
    // because the magnitudes are treated as unsigned from here on.
    a_mag          = a_neg ? (32'd0 - src_a) : src_a;
    b_mag          = b_neg ? (32'd0 - src_b) : src_b;
    div_by_zero    = (src_b == 32'd0);
    overflow       = req_signed && (src_a == INT_MIN) && (src_b == 32'hFFFF_FFFF);
    special        = div_by_zero | overflow;
    special_result = 32'd0;
    if (div_by_zero) begin
      special_result = req_is_rem ? src_a : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_result = req_is_rem ? 32'd0 : INT_MIN;
    end
    // flush has priority, so a request in a flush cycle is never taken.
    accept         = req_valid && req_ready && !flush;
  end

  // ---------------------------------------------------------------------------
  // One restoring step, plus the sign fix used on the final step
  // ---------------------------------------------------------------------------
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        q_bit;
  logic [32:0] rem_next;
  logic [31:0] dividend_next;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] final_result;

  always_comb begin
    // The remainder is always below the divisor, so rem_q[32] is zero and
    // the cast simply drops it when the next dividend bit shifts in.
    rem_shift     = 33'({rem_q, dividend_q[31]});
    trial         = rem_shift - {1'b0, divisor_q};
    q_bit         = ~trial[32];
    rem_next      = q_bit ? trial : rem_shift;
    dividend_next = {dividend_q[30:0], q_bit};

    quot_fixed    = dividend_next;
    if ((op_q == OP_DIV) && (sign_a_q ^ sign_b_q)) begin
      quot_fixed = 32'd0 - dividend_next;
    end
    // The remainder takes the sign of the dividend.
    rem_fixed     = rem_next[31:0];
    if ((op_q == OP_REM) && sign_a_q) begin
      rem_fixed = 32'd0 - rem_next[31:0];
    end
    final_result  = op_q[1] ? rem_fixed : quot_fixed;
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state is assigned with non-blocking (<=) so every
  // register samples the values from before the edge, whatever order the
  // statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      rem_q      <= 33'd0;
      count_q    <= 5'd0;
      result_q   <= 32'd0;
    end else if (flush) begin
      // Only the state is dropped. The stale datapath values are harmless
      // because nothing reads them until the next accept reloads them.
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (special) begin
              result_q <= special_result;
              state_q  <= ST_DONE;
            end else begin
              op_q       <= req_op;
              sign_a_q   <= a_neg;
              sign_b_q   <= b_neg;
              dividend_q <= a_mag;
              divisor_q  <= b_mag;
              rem_q      <= 33'd0;
              count_q    <= 5'd0;
              state_q    <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          rem_q      <= rem_next;
          dividend_q <= dividend_next;
          if (count_q == 5'd31) begin
            result_q <= final_result;
            state_q  <= ST_DONE;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end

        ST_DONE: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_divider.sv
module tb_core_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  core_divider dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  always #5 clk = ~clk;

  // Move to just after the next rising edge. Inputs are driven and outputs
  // are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, check its latency and value,
  // then consume it and check that the unit goes back to IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input string name);
    int lat;
    req_op     = op;
    src_a      = a;
    src_b      = b;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: req_ready=%b expected 1", name, req_ready);
    end
    tick();
    // The operands are scrambled after the accept edge, so the result can
    // only come out right if the unit latched them at the accept edge.
    req_valid = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
    req_op    = 2'($urandom);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (resp_result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, resp_result, exp_res);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: req_ready=%b resp_valid=%b expected 1/0",
               name, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b result=%h expected 0/1/00000000",
               resp_valid, req_ready, resp_result);
    end
  endtask

  task automatic test_signed();
    run_op(DIV, 32'h0000_0014, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFA, "div_20_m3");
    run_op(REM, 32'h0000_0014, 32'hFFFF_FFFD, 33, 32'h0000_0002, "rem_20_m3");
    run_op(REM, 32'hFFFF_FFEC, 32'h0000_0003, 33, 32'hFFFF_FFFE, "rem_m20_3");
    run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, "div_m7_2");
    run_op(REM, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(DIV, 32'h8000_0000, 32'h0000_0002, 33, 32'hC000_0000, "div_min_2");
    run_op(DIV, 32'h0000_0064, 32'h0000_0007, 33, 32'h0000_000E, "div_100_7");
  endtask

  task automatic test_unsigned();
    run_op(DIVU, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'h7FFF_FFFF, "divu_max_2");
    run_op(REMU, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'h0000_0001, "remu_max_2");
    run_op(DIVU, 32'h8000_0000, 32'h8000_0000, 33, 32'h0000_0001, "divu_min_min");
  endtask

  task automatic test_div_by_zero();
    run_op(DIV,  32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, "div_by0");
    run_op(DIVU, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    run_op(REM,  32'h1234_5678, 32'd0, 1, 32'h1234_5678, "rem_by0");
    run_op(REMU, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, "remu_by0");
  endtask

  task automatic test_overflow();
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, "div_ovf");
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0000_0000, "rem_ovf");
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, "divu_ovf_ops");
    run_op(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, "remu_ovf_ops");
  endtask

  task automatic test_backpressure();
    int lat;
    req_op    = DIV;
    src_a     = 32'd100;
    src_b     = 32'd7;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected 33", lat);
    end
    // Hold the result for 10 cycles. Meanwhile change the operands and offer
    // a request, which must be ignored.
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      src_a     = $urandom;
      src_b     = $urandom;
      tick();
      n_checks++;
      if (resp_result !== 32'd14 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: result=%h valid=%b ready=%b expected 0000000e/1/0",
                 i, resp_result, resp_valid, req_ready);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b valid=%b expected 1/0", req_ready, resp_valid);
    end
  endtask

  // Abort a running divide at T+15, using flush (use_rst=0) or reset
  // (use_rst=1). Check that no response ever appears.
  task automatic test_abort(input bit use_rst, input string name);
    bit saw_valid;
    saw_valid = 1'b0;
    req_op    = DIV;
    src_a     = 32'd1000;
    src_b     = 32'd3;
    req_valid = 1'b1;
    tick();                               // now in T+1
    req_valid = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      tick();
      if (resp_valid === 1'b1) saw_valid = 1'b1;
    end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_next: ready=%b valid=%b expected 1/0",
               name, req_ready, resp_valid);
    end
    if (use_rst) begin
      n_checks++;
      if (resp_result !== 32'd0) begin
        n_fail++;
        $display("FAIL %s result_cleared: got %h expected 00000000", name, resp_result);
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid === 1'b1) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL %s no_resp: resp_valid was seen 1, expected never", name);
    end
    run_op(DIV, 32'd100, 32'd7, 33, 32'd14, {name, "_fresh"});
  endtask

  // A request in the same cycle as flush must be dropped. A divide-by-zero
  // request would otherwise show resp_valid one cycle later.
  task automatic test_flush_same_cycle();
    req_op    = DIVU;
    src_a     = 32'h1234_5678;
    src_b     = 32'd0;
    req_valid = 1'b1;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_same_cycle: valid=%b ready=%b expected 0/1",
               resp_valid, req_ready);
    end
  endtask

  // Flushing in DONE drops the result that was waiting there.
  task automatic test_flush_done();
    req_op    = REMU;
    src_a     = 32'h1234_5678;
    src_b     = 32'd0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_setup: valid=%b expected 1", resp_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: valid=%b ready=%b expected 0/1", resp_valid, req_ready);
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    req_op     = DIV;
    src_a      = 32'd0;
    src_b      = 32'd0;

    test_reset();
    test_signed();
    test_unsigned();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_abort(1'b0, "flush_t15");
    test_abort(1'b1, "rst_t15");
    test_flush_same_cycle();
    test_flush_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
